// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, 1-entry skid buffer and flush.
// out_data comes straight from the main register; the skid register absorbs one beat of backpressure.
module pipe_stage_reg #(
    parameter int          N      = 32,
    parameter logic [N-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         in_ready_q;
    logic [N-1:0] m_q, m_d;
    logic [N-1:0] s_q, s_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready;

    // Next state and storage updates; in_data is only loaded on in_fire.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
            m_d     = BUBBLE;
            s_d     = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        m_d     = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        s_d     = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        m_d     = s_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_q        <= BUBBLE;
            s_q        <= BUBBLE;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            m_q        <= m_d;
            s_q        <= s_d;
        end
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != EMPTY);
        out_data  = m_q;
        count     = state_q;
    end

endmodule
